if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//  Instruction-fetch front end that sits directly upstream of the 5-stage datapath's IF/ID register.
//  Issues sequential word fetches to a multi-cycle instruction memory over a req/ack handshake.
//  Buffers the returned words with their PC in a small FIFO and presents the FIFO head to IF/ID.
//  Branch and jump resolution in ID redirects the queue: the queue is flushed and fetch restarts at the new PC.
// PARAMETERS
//  DEPTH     4             FIFO entries (power of 2, >=2)
//  RESET_PC  32'h00000000  first fetch address after reset
// PORTS
//  clk           in   1   rising-edge clock (single clock domain)
//  rst           in   1   reset, asynchronous, active-low
//  imem_req      out  1   fetch request; held until imem_ack
//  imem_addr     out  32  word address of the request; stable while imem_req=1
//  imem_ack      in   1   1-cycle pulse: imem_rdata is valid for the outstanding request
//  imem_rdata    in   32  returned instruction word
//  inst_valid    out  1   FIFO head is valid
//  inst_out      out  32  FIFO head instruction
//  inst_pc       out  32  PC of the FIFO head
//  inst_pc_plus4 out  32  inst_pc + 4 (wraps modulo 2^32)
//  inst_pop      in   1   IF/ID consumes the head this cycle (tied to IF_ID_write); ignored when inst_valid=0
//  redirect      in   1   taken branch or jump resolved in ID
//  redirect_pc   in   32  new fetch PC; low 2 bits are forced to 0
// BEHAVIOUR
//  Reset (rst=0, async): FIFO count=0, rd/wr ptr=0, fetch_pc=RESET_PC, imem_req=0, inst_valid=0,
//   inst_out/inst_pc/inst_pc_plus4=0, state=S_FETCH. Reset mid-transaction abandons the request;
//   the memory must tolerate req dropping on reset.
//  Credit rule: a request is issued only when count + outstanding < DEPTH. A returning ack therefore always has space.
//  At most one request is outstanding at any time.
//  FSM:
//   S_FETCH:   if credit available, drive imem_req=1 and imem_addr=fetch_pc on the next edge, then go to S_WAIT.
//   S_WAIT:    on imem_ack, push {imem_rdata, fetch_pc}, set fetch_pc+=4, and go to S_FETCH.
//              The next req can assert the cycle after the ack (back-to-back throughput of 1 fetch per 2 cycles minimum).
//              On redirect without ack: fetch_pc=redirect_pc, flush, go to S_DISCARD.
//              On redirect with ack in the same cycle: drop the data, fetch_pc=redirect_pc, flush, go to S_FETCH.
//   S_DISCARD: req stays high with the old address until ack; the ack data is dropped, then go to S_FETCH.
//              A further redirect here only updates fetch_pc.
//  Redirect in S_FETCH with no request pending: flush, fetch_pc=redirect_pc.
//  Flush: count=0 and ptrs=0 on the next edge, so inst_valid=0 in the following cycle.
//  Latency: ack at edge N makes the data visible on inst_* after edge N+1.
//   No bypass from imem_rdata to inst_out.
//  Pop: head advances on the edge. Push+pop in the same cycle leaves count unchanged.
//   Pointers wrap modulo DEPTH.
//  Redirect and pop in the same cycle: redirect wins and the pop is ignored.
//  fetch_pc wraps 32'hFFFFFFFC -> 32'h00000000 without error.
// CONFIGURATION
//  PREFETCH_STATS_EN defined: adds three outputs:
//   - stat_fetches [15:0]: accepted (pushed) fetches
//   - stat_flushes [15:0]: redirects
//   - stat_starve [15:0]: cycles with inst_valid=0 while not in reset
//   All three saturate at 16'hFFFF and reset to 0.
//  PREFETCH_STATS_EN undefined: the ports and counters are absent and the rest of the behaviour is identical.
// TESTING
//  1. Reset release, memory acks 1 cycle after each req, inst_pop=0
//     -> addrs 0x0,0x4,0x8,0xC fetched; no 5th req; inst_valid=1 with inst_pc=0x0, inst_pc_plus4=0x4.
//  2. Full queue (DEPTH=4), pop 1 head -> one new req at addr 0x10; head becomes pc 0x4.
//  3. redirect=1, redirect_pc=0x40 while in S_WAIT on addr 0x8, ack 3 cycles later
//     -> inst_valid=0 next cycle; ack data dropped; next req addr=0x40; first valid inst_pc=0x40.
//  4. redirect_pc=0x80 in the same cycle as ack and pop -> data dropped, no pop, count=0, next req addr=0x80.
//  5. Assert rst=0 asynchronously mid-S_WAIT -> imem_req=0 and inst_valid=0 immediately;
//     after release the first req addr equals RESET_PC.
//  6. With PREFETCH_STATS_EN, run scenario 3 -> stat_flushes=1, stat_fetches excludes the dropped word;
//     redirect_pc=0xFFFFFFFC -> next fetch addr 0x0.

Source files
------------

// File: rtl/if_prefetch_queue.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// if_prefetch_queue
//
// Instruction-fetch front end that sits in front of the IF/ID register.
// It issues sequential word fetches to a multi-cycle instruction memory and
// buffers the returned words, together with their PC, in a small FIFO. The
// FIFO head is presented to IF/ID. A redirect from ID flushes the FIFO and
// restarts fetching at the new PC.
//
// Parameters
//   DEPTH     FIFO entries (power of 2, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   imem_req      fetch request, held until imem_ack
//   imem_addr     word address of the request, stable while imem_req=1
//   imem_ack      1-cycle pulse: imem_rdata valid for the outstanding request
//   imem_rdata    returned instruction word
//   inst_valid    FIFO head is valid
//   inst_out      FIFO head instruction (0 when inst_valid=0)
//   inst_pc       PC of the FIFO head (0 when inst_valid=0)
//   inst_pc_plus4 inst_pc + 4, wraps modulo 2^32 (0 when inst_valid=0)
//   inst_pop      IF/ID consumes the head this cycle; ignored if inst_valid=0
//   redirect      taken branch/jump resolved in ID
//   redirect_pc   new fetch PC; low 2 bits are forced to 0
//   dbg_state     current fetch FSM state (S_FETCH/S_WAIT/S_DISCARD)
//
// Optional feature (macro PREFETCH_STATS_EN):
//   stat_fetches  pushed fetches, saturating at 16'hFFFF
//   stat_flushes  redirect cycles, saturating at 16'hFFFF
//   stat_starve   cycles out of reset with inst_valid=0, saturating
//
// Handshakes:
//   imem side is req/ack: imem_req rises with imem_addr and both stay
//   constant until the cycle in which imem_ack=1 is sampled; req drops on
//   that edge. Only one request is ever outstanding.
//   IF/ID side is valid/pop: a word transfers on an edge where inst_valid=1
//   and inst_pop=1 (and no redirect); inst_* are stable until that edge.
// -----------------------------------------------------------------------------
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4,
  input  logic        inst_pop,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [1:0]  dbg_state
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0] stat_fetches,
  output logic [15:0] stat_flushes,
  output logic [15:0] stat_starve
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(DEPTH);

  logic [1:0]       state;
  logic [31:0]      fetch_pc;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic [31:0] data_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic [31:0]  redirect_pc_w;
  logic [CNT_W:0] inflight;
  logic         credit;
  logic         push;
  logic         pop_ok;
  logic         unused_redirect_low;

  // Redirect targets are word aligned; the low bits are simply discarded.
  assign redirect_pc_w       = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_low = ^redirect_pc[1:0];

  // Credit counts the outstanding request (imem_req) against free space so an
  // ack can never find the FIFO full.
  assign inflight = {1'b0, count} + {{CNT_W{1'b0}}, imem_req};
  assign credit   = (inflight < DEPTH_W);

  // A word is only kept when it answers a live request in S_WAIT and no
  // redirect arrives in the same cycle; a same-cycle redirect discards it.
  assign push   = imem_ack && (state == S_WAIT) && !redirect;
  assign pop_ok = inst_pop && inst_valid && !redirect;

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping. A redirect clears count and pointers on the next edge,
  // which makes inst_valid fall in the following cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible unless count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch FSM.
  // imem_addr is its own register because in S_DISCARD the request must keep
  // its old address while fetch_pc already holds the redirect target.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= 32'h0000_0000;
    end else begin
      case (state)
        S_FETCH: begin
          if (redirect) begin
            fetch_pc <= redirect_pc_w;
          end else if (credit) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
            state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= S_FETCH;
            // With a same-cycle redirect the word is dropped by push=0.
            fetch_pc <= redirect ? redirect_pc_w : (fetch_pc + 32'd4);
          end else if (redirect) begin
            fetch_pc <= redirect_pc_w;
            state    <= S_DISCARD;
          end
        end

        S_DISCARD: begin
          // The stale request still has to complete; its data is ignored.
          if (redirect) begin
            fetch_pc <= redirect_pc_w;
          end
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= S_FETCH;
          end
        end

        default: begin
          imem_req <= 1'b0;
          state    <= S_FETCH;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Head presentation. No bypass from imem_rdata: a word becomes visible only
  // after it has been written into the FIFO.
  // ---------------------------------------------------------------------------
  always_comb begin
    inst_valid    = (count != '0);
    inst_out      = 32'h0000_0000;
    inst_pc       = 32'h0000_0000;
    inst_pc_plus4 = 32'h0000_0000;
    if (inst_valid) begin
      inst_out      = data_mem[rd_ptr];
      inst_pc       = pc_mem[rd_ptr];
      inst_pc_plus4 = pc_mem[rd_ptr] + 32'd4;
    end
  end

  assign dbg_state = state;

`ifdef PREFETCH_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating event counters.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetches <= 16'h0000;
      stat_flushes <= 16'h0000;
      stat_starve  <= 16'h0000;
    end else begin
      if (push && (stat_fetches != 16'hFFFF)) begin
        stat_fetches <= stat_fetches + 16'd1;
      end
      if (redirect && (stat_flushes != 16'hFFFF)) begin
        stat_flushes <= stat_flushes + 16'd1;
      end
      if (!inst_valid && (stat_starve != 16'hFFFF)) begin
        stat_starve <= stat_starve + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_if_prefetch_queue
//
// Directed bench for if_prefetch_queue (DEPTH=4, RESET_PC=0). A small memory
// model answers requests with word_of(addr) after a programmable latency or on
// demand. A monitor compares every new request address against exp_addr_q and
// every consumed head against exp_q. Define PREFETCH_STATS_EN to also check
// the statistics counters.
// -----------------------------------------------------------------------------
module tb_if_prefetch_queue;

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic        inst_pop;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  dbg_state;
`ifdef PREFETCH_STATS_EN
  logic [15:0] stat_fetches;
  logic [15:0] stat_flushes;
  logic [15:0] stat_starve;
`endif

  if_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc),
    .inst_pc_plus4 (inst_pc_plus4),
    .inst_pop      (inst_pop),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .dbg_state     (dbg_state)
`ifdef PREFETCH_STATS_EN
    ,
    .stat_fetches  (stat_fetches),
    .stat_flushes  (stat_flushes),
    .stat_starve   (stat_starve)
`endif
  );

  // ---------------------------------------------------------------- scoreboard
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_q[$];          // {pc, instruction} of each expected pop
  int          n_checks = 0;
  int          n_errors = 0;

  // memory model knobs
  int   mem_lat    = 1;
  logic mem_manual = 1'b0;
  logic ack_now    = 1'b0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_pop(input logic [31:0] pc);
    exp_q.push_back({pc, word_of(pc)});
    inst_pop = 1'b1;
    tick();
    inst_pop = 1'b0;
  endtask

  // Returns at a negedge with the request to addr visible, or reports timeout.
  task automatic wait_req(input logic [31:0] addr, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(imem_req && imem_addr == addr) && n < budget);
    if (!(imem_req && imem_addr == addr)) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_req: no request to %h within %0d cycles", addr, budget);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    @(negedge clk);
    check({tag, "_valid"}, 32'(inst_valid), 32'd1);
    check({tag, "_pc"}, inst_pc, pc);
    check({tag, "_inst"}, inst_out, word_of(pc));
    check({tag, "_pc_plus4"}, inst_pc_plus4, pc + 32'd4);
    tick();
  endtask

  // Memory: acks mem_lat cycles after req is first seen, or when ack_now is
  // raised in manual mode. Acts 1 time unit after the rising edge.
  task automatic mem_loop();
    int wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_ack) begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end else if (!imem_req) begin
        wait_cnt = 0;
      end else if (mem_manual) begin
        if (ack_now) begin
          imem_ack   = 1'b1;
          imem_rdata = word_of(imem_addr);
          ack_now    = 1'b0;
        end
      end else begin
        wait_cnt++;
        if (wait_cnt >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = word_of(imem_addr);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------- monitor
  task automatic monitor_loop();
    logic        req_prev = 1'b0;
    logic [31:0] ea;
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (imem_req && !req_prev) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_req: addr %h with none expected", imem_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          check("req_addr", imem_addr, ea);
        end
      end
      req_prev = imem_req;
      if (rst && inst_pop && !redirect) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pop: pc %h with none expected", inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("pop_valid", 32'(inst_valid), 32'd1);
          check("pop_pc", inst_pc, e[63:32]);
          check("pop_inst", inst_out, e[31:0]);
          check("pop_pc_plus4", inst_pc_plus4, e[63:32] + 32'd4);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    rst         = 1'b0;
    inst_pop    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    fork
      mem_loop();
      monitor_loop();
    join_none

    // Reset values, then four fetches with a 1-cycle memory and no pops.
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst_out, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_pc_plus4", inst_pc_plus4, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_FETCH));
`ifdef PREFETCH_STATS_EN
    check("rst_stat_fetches", 32'(stat_fetches), 32'd0);
`endif
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    exp_addr_q.push_back(32'hC);
    tick();
    rst = 1'b1;
    repeat (14) tick();
    check_head("t1", 32'h0);
    check("t1_no_5th_req", 32'(imem_req), 32'd0);
    check("t1_reqs_left", 32'(exp_addr_q.size()), 32'd0);

    // Pop one from the full queue: exactly one refill at 0x10.
    exp_addr_q.push_back(32'h10);
    do_pop(32'h0);
    repeat (6) tick();
    check_head("t2", 32'h4);
    check("t2_req", 32'(imem_req), 32'd0);
    check("t2_reqs_left", 32'(exp_addr_q.size()), 32'd0);

    // Asynchronous reset in the middle of S_WAIT.
    mem_lat = 3;
    exp_addr_q.push_back(32'h14);
    do_pop(32'h4);
    wait_req(32'h14, 10);
    check("t5_state_wait", 32'(dbg_state), 32'(S_WAIT));
    #1 rst = 1'b0;
    #1;
    check("t5_req", 32'(imem_req), 32'd0);
    check("t5_valid", 32'(inst_valid), 32'd0);
    check("t5_pc", inst_pc, 32'd0);
    check("t5_state", 32'(dbg_state), 32'(S_FETCH));
`ifdef PREFETCH_STATS_EN
    check("t5_stat_fetches", 32'(stat_fetches), 32'd0);
    check("t5_stat_flushes", 32'(stat_flushes), 32'd0);
    check("t5_stat_starve", 32'(stat_starve), 32'd0);
`endif
    repeat (2) tick();
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    rst = 1'b1;
    repeat (3) @(negedge clk);
`ifdef PREFETCH_STATS_EN
    check("t5_stat_starve_run", 32'(stat_starve), 32'd2);
`endif

    // Redirect to 0x40 while waiting on 0x8; the late ack is discarded.
    wait_req(32'h8, 40);
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    exp_addr_q.push_back(32'h40);
    exp_addr_q.push_back(32'h44);
    exp_addr_q.push_back(32'h48);
    exp_addr_q.push_back(32'h4C);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("t3_valid", 32'(inst_valid), 32'd0);
    check("t3_state", 32'(dbg_state), 32'(S_DISCARD));
    check("t3_req_held", 32'(imem_req), 32'd1);
    check("t3_addr_held", imem_addr, 32'h8);
    repeat (24) tick();
    check_head("t3", 32'h40);
    check("t3_reqs_left", 32'(exp_addr_q.size()), 32'd0);
`ifdef PREFETCH_STATS_EN
    check("t6_stat_fetches", 32'(stat_fetches), 32'd6);
    check("t6_stat_flushes", 32'(stat_flushes), 32'd1);
`endif

    // Drain the four words back to back; the queue refills behind them.
    exp_addr_q.push_back(32'h50);
    exp_addr_q.push_back(32'h54);
    exp_addr_q.push_back(32'h58);
    exp_addr_q.push_back(32'h5C);
    for (int i = 0; i < 4; i++) begin
      do_pop(32'h40 + 32'(4 * i));
    end
    repeat (30) tick();
    check_head("t3b", 32'h50);

    // Redirect, ack and pop in the same cycle.
    mem_manual = 1'b1;
    exp_addr_q.push_back(32'h60);
    do_pop(32'h50);
    wait_req(32'h60, 10);
    ack_now = 1'b1;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    inst_pop    = 1'b1;
    exp_addr_q.push_back(32'h80);
    exp_addr_q.push_back(32'h84);
    exp_addr_q.push_back(32'h88);
    exp_addr_q.push_back(32'h8C);
    mem_manual = 1'b0;
    mem_lat    = 1;
    tick();
    redirect = 1'b0;
    inst_pop = 1'b0;
    @(negedge clk);
    check("t4_valid", 32'(inst_valid), 32'd0);
    check("t4_req", 32'(imem_req), 32'd0);
    check("t4_state", 32'(dbg_state), 32'(S_FETCH));
    repeat (12) tick();
    check_head("t4", 32'h80);

    // Redirect with unaligned target near the top: alignment and wrap.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("wrap_flush_valid", 32'(inst_valid), 32'd0);
    repeat (12) tick();
    check_head("wrap", 32'hFFFF_FFFC);

    // Pops overlapping refills (push and pop on the same edge).
    exp_addr_q.push_back(32'hC);
    exp_addr_q.push_back(32'h10);
    exp_addr_q.push_back(32'h14);
    do_pop(32'hFFFF_FFFC);
    do_pop(32'h0);
    do_pop(32'h4);
    repeat (10) tick();
    check_head("wrap2", 32'h8);
    check("end_req", 32'(imem_req), 32'd0);
    check("end_reqs_left", 32'(exp_addr_q.size()), 32'd0);
    check("end_pops_left", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
